// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC-32 definitions for the packet CRC generator and checker
package crc_pkg;

  typedef enum logic [2:0] {IDLE, PAYLOAD, TRAILER, CHECK, REPORT} state_t;

  localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;

  // Reflected CRC: data bits enter LSB first, register shifts right.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data,
                                             input logic [31:0] poly = CRC32_POLY);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_checker.sv
// rtl/crc_checker.sv - receive-side CRC-32 check of a fixed-size payload plus 4-byte trailer
module crc_checker
  import crc_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 32,
  parameter logic [31:0] CRC_POLY      = CRC32_POLY,
  parameter logic [31:0] CRC_INIT      = CRC32_INIT,
  parameter logic [31:0] CRC_XOROUT    = CRC32_XOROUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [7:0]   in_byte,
  input  logic         in_last,
  output logic         in_ready,
  output logic [255:0] data_out,
  output logic [31:0]  crc_rx,
  output logic [31:0]  crc_calc,
  output logic         crc_ok,
  output logic         frame_err,
  output logic         done
);

  localparam logic [5:0] LAST_IDX = 6'(PAYLOAD_BYTES - 1);

  state_t       state;
  logic [31:0]  crc_reg;
  logic [5:0]   byte_cnt;
  logic [1:0]   trl_cnt;
  logic         err;
  logic [255:0] data_buf;
  logic [31:0]  rx_buf;
  logic         accept;

  assign in_ready = rst_n && (state == IDLE || state == PAYLOAD || state == TRAILER);
  assign accept   = in_valid && in_ready;

  // Frame assembly happens in data_buf/rx_buf so the outputs hold the last result until CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      crc_reg   <= CRC_INIT;
      byte_cnt  <= 6'd0;
      trl_cnt   <= 2'd0;
      err       <= 1'b0;
      data_buf  <= '0;
      rx_buf    <= '0;
      data_out  <= '0;
      crc_rx    <= '0;
      crc_calc  <= '0;
      crc_ok    <= 1'b0;
      frame_err <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, PAYLOAD: begin
          if (accept) begin
            crc_reg <= crc32_byte(crc_reg, in_byte, CRC_POLY);
            data_buf[8'd255 - {byte_cnt[4:0], 3'b000} -: 8] <= in_byte;
            byte_cnt <= byte_cnt + 6'd1;
            trl_cnt  <= 2'd0;
            if (in_last) begin
              err   <= 1'b1;
              state <= CHECK;
            end else if (byte_cnt == LAST_IDX) begin
              state <= TRAILER;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        TRAILER: begin
          if (accept) begin
            rx_buf[{trl_cnt, 3'b000} +: 8] <= in_byte;
            trl_cnt <= trl_cnt + 2'd1;
            if (trl_cnt == 2'd3) begin
              if (!in_last) err <= 1'b1;
              state <= CHECK;
            end else if (in_last) begin
              err   <= 1'b1;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          crc_calc  <= crc_reg ^ CRC_XOROUT;
          crc_ok    <= ((crc_reg ^ CRC_XOROUT) == rx_buf) && !err;
          frame_err <= err;
          data_out  <= data_buf;
          crc_rx    <= rx_buf;
          done      <= 1'b1;
          state     <= REPORT;
        end
        REPORT: begin
          crc_reg  <= CRC_INIT;
          byte_cnt <= 6'd0;
          trl_cnt  <= 2'd0;
          err      <= 1'b0;
          data_buf <= '0;
          rx_buf   <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_checker.sv
// tb/tb_crc_checker.sv - directed table-driven bench for crc_checker (9-byte and 32-byte payloads)
module tb_crc_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cur = 0;
  logic tv = 1'b0, tlast = 1'b0;
  logic [7:0] tbyte = 8'h00;

  logic v9, v32, r9, r32, ok9, ok32, fe9, fe32, d9, d32;
  logic [255:0] do9, do32;
  logic [31:0] rx9, rx32, cc9, cc32;

  assign v9  = tv && (cur == 0);
  assign v32 = tv && (cur == 1);

  crc_checker #(.PAYLOAD_BYTES(9)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(v9), .in_byte(tbyte), .in_last(tlast),
    .in_ready(r9), .data_out(do9), .crc_rx(rx9), .crc_calc(cc9),
    .crc_ok(ok9), .frame_err(fe9), .done(d9));

  crc_checker #(.PAYLOAD_BYTES(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_byte(tbyte), .in_last(tlast),
    .in_ready(r32), .data_out(do32), .crc_rx(rx32), .crc_calc(cc32),
    .crc_ok(ok32), .frame_err(fe32), .done(d32));

  logic s_ready, s_ok, s_ferr, s_done;
  logic [255:0] s_data;
  logic [31:0] s_rx, s_calc;
  assign s_ready = cur == 1 ? r32  : r9;
  assign s_ok    = cur == 1 ? ok32 : ok9;
  assign s_ferr  = cur == 1 ? fe32 : fe9;
  assign s_done  = cur == 1 ? d32  : d9;
  assign s_data  = cur == 1 ? do32 : do9;
  assign s_rx    = cur == 1 ? rx32 : rx9;
  assign s_calc  = cur == 1 ? cc32 : cc9;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           sel;
    logic [255:0] pay;
    logic [31:0]  trl;
    int           last_pos;
    bit           gaps;
    logic [31:0]  e_calc;
    logic [31:0]  e_rx;
    logic         e_ok;
    logic         e_ferr;
    logic [255:0] e_data;
    logic [2:0]   mask;
  } vec_t;

  localparam logic [255:0] P9 = {72'h313233343536373839, 184'h0};

  vec_t vt[8];
  logic [7:0] stm[0:63];
  logic       stl[0:63];
  int n_err = 0, n_chk = 0;
  int acc_cyc = 0;

  bit mon_en = 0;
  int mon_done = 0, mon_rlow = 0, mon_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!s_ready) mon_rlow++;
      if (s_done) begin
        mon_done++;
        if (!s_ok || s_calc != 32'hCBF43926) mon_bad++;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build(input int i, input int base, output int n);
    int plen, total;
    plen  = vt[i].sel == 1 ? 32 : 9;
    total = plen + 4;
    n = (vt[i].last_pos >= 0 && vt[i].last_pos < total) ? vt[i].last_pos + 1 : total;
    for (int k = 0; k < total; k++) begin
      stm[base + k] = k < plen ? vt[i].pay[255 - 8*k -: 8] : vt[i].trl[8*(k - plen) +: 8];
      stl[base + k] = (k == vt[i].last_pos);
    end
  endtask

  task automatic drive(input int n, input bit gaps);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      tv    = gaps ? ($urandom_range(1) == 1) : 1'b1;
      tbyte = stm[i];
      tlast = stl[i];
      #1;
      if (tv && s_ready) begin
        acc_cyc = cyc;
        i++;
      end
    end
    check("drive_budget", 256'(i), 256'(n));
  endtask

  task automatic wait_done();
    bit found, rdy_bad;
    found = 0;
    rdy_bad = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      tv = 1'b0;
      tlast = 1'b0;
      if (s_ready) rdy_bad = 1;
      if (s_done) found = 1;
    end
    check("done_seen", 256'(found), 256'(1));
    check("done_latency", 256'(cyc - acc_cyc), 256'(2));
    check("ready_low_check_report", 256'(rdy_bad), 256'(0));
    @(negedge clk);
    check("done_one_cycle", 256'(s_done), 256'(0));
    check("ready_back_idle", 256'(s_ready), 256'(1));
  endtask

  task automatic run_vec(input int i);
    int n;
    cur = vt[i].sel;
    build(i, 0, n);
    drive(n, vt[i].gaps);
    wait_done();
    check($sformatf("v%0d_crc_ok", i), 256'(s_ok), 256'(vt[i].e_ok));
    check($sformatf("v%0d_frame_err", i), 256'(s_ferr), 256'(vt[i].e_ferr));
    if (vt[i].mask[0]) check($sformatf("v%0d_crc_calc", i), 256'(s_calc), 256'(vt[i].e_calc));
    if (vt[i].mask[1]) check($sformatf("v%0d_crc_rx", i), 256'(s_rx), 256'(vt[i].e_rx));
    if (vt[i].mask[2]) check($sformatf("v%0d_data_out", i), s_data, vt[i].e_data);
  endtask

  initial begin
    int n;
    vt[0] = '{0, P9, 32'hCBF43926, 12, 0, 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, P9, 3'b111};
    vt[1] = '{0, P9, 32'hCBF43926, 12, 1, 32'hCBF43926, 32'hCBF43926, 1'b1, 1'b0, P9, 3'b111};
    vt[2] = '{1, '0, 32'h190A55AD, 35, 0, 32'h190A55AD, 32'h190A55AD, 1'b1, 1'b0, '0, 3'b111};
    vt[3] = '{1, '0, 32'h190A55AC, 35, 0, 32'h190A55AD, 32'h190A55AC, 1'b0, 1'b0, '0, 3'b111};
    vt[4] = '{1, '0, 32'h190A55AD, 10, 0, 32'h0, 32'h0, 1'b0, 1'b1, '0, 3'b100};
    vt[5] = '{1, '0, 32'h190A55AD, 35, 0, 32'h190A55AD, 32'h190A55AD, 1'b1, 1'b0, '0, 3'b111};
    vt[6] = '{1, '0, 32'h190A55AD, -1, 0, 32'h190A55AD, 32'h190A55AD, 1'b0, 1'b1, '0, 3'b111};
    vt[7] = '{0, P9, 32'hCBF43926, 10, 0, 32'hCBF43926, 32'h0, 1'b0, 1'b1, P9, 3'b101};

    #2;
    check("rst_ready9", 256'(r9), 256'(0));
    check("rst_ready32", 256'(r32), 256'(0));
    check("rst_data_out", do32, '0);
    check("rst_crc_calc", 256'(cc9), 256'(0));
    check("rst_crc_rx", 256'(rx9), 256'(0));
    check("rst_flags", 256'({ok9, fe9, d9, ok32, fe32, d32}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_ready", 256'({r9, r32}), 256'(2'b11));

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset in the middle of a payload, then a clean frame.
    cur = 0;
    build(0, 0, n);
    drive(5, 0);
    @(negedge clk);
    tv = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_data_out", do9, '0);
    check("midrst_crc_calc", 256'(cc9), 256'(0));
    check("midrst_flags", 256'({ok9, fe9, d9, r9}), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);

    // Three frames back to back with in_valid held high.
    cur = 0;
    for (int f = 0; f < 3; f++) build(0, 13*f, n);
    mon_done = 0;
    mon_rlow = 0;
    mon_bad = 0;
    mon_en = 1;
    drive(39, 0);
    @(negedge clk);
    tv = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 0;
    check("b2b_done_count", 256'(mon_done), 256'(3));
    check("b2b_ready_low_cycles", 256'(mon_rlow), 256'(6));
    check("b2b_bad_results", 256'(mon_bad), 256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
